// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg -- shared types for the instruction fetch stage.
//   addr_t / inst_t     : 32-bit fetch address and instruction word
//   fetch_state_e       : fetch FSM states
//   RESET_PC_DEFAULT    : default first fetch address after reset
package inst_fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam addr_t RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if -- instruction bus between the fetch stage and memory.
//   inst_req / inst_addr : request and its address (held until inst_addr_ok)
//   inst_addr_ok         : address accepted this cycle
//   inst_data_ok         : read data valid this cycle
//   inst_rdata           : returned instruction word
// master = fetch stage, slave = memory side.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic  inst_req;
  addr_t inst_addr;
  logic  inst_addr_ok;
  logic  inst_data_ok;
  inst_t inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/inst_fetch.sv
// inst_fetch -- single-outstanding instruction fetch stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : downstream not accepting the held instruction
//   flush / flush_pc    : exception redirect (wins over branch)
//   branch_flag / branch_target : branch redirect
//   bus (master)        : instruction bus, see inst_fetch_if
//   if_pc/if_inst/if_valid/if_adel : presented instruction
// Parameter RESET_PC: first fetch address after reset.
// Optional macro FETCH_ADEL_EN: misaligned PCs raise if_adel instead of
// issuing a bus request. Without it if_adel stays 0 and the PC goes to the
// bus unchanged.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  addr_t        flush_pc,
  input  logic         branch_flag,
  input  addr_t        branch_target,
  inst_fetch_if.master bus,
  output addr_t        if_pc,
  output inst_t        if_inst,
  output logic         if_valid,
  output logic         if_adel
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         cancel_q, cancel_d;
  logic         inst_req_q, inst_req_d;
  addr_t        inst_addr_q, inst_addr_d;
  addr_t        if_pc_q, if_pc_d;
  inst_t        if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;
  logic         if_adel_q, if_adel_d;

  logic  redirect;
  addr_t redir_tgt;
  logic  enter_req;

  assign redirect  = flush | branch_flag;
  assign redir_tgt = flush ? flush_pc : branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cancel_q    <= 1'b0;
      inst_req_q  <= 1'b0;
      inst_addr_q <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      if_adel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cancel_q    <= cancel_d;
      inst_req_q  <= inst_req_d;
      inst_addr_q <= inst_addr_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      if_adel_q   <= if_adel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cancel_d    = cancel_q;
    inst_req_d  = inst_req_q;
    inst_addr_d = inst_addr_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    if_adel_d   = if_adel_q;
    enter_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redir_tgt;
        enter_req = 1'b1;
      end

      S_REQ: begin
        if (!inst_req_q) begin
          // In REQ without a raised request only happens for a misaligned PC:
          // nothing is on the bus, so a redirect simply restarts REQ.
          if (redirect) begin
            pc_d      = redir_tgt;
            enter_req = 1'b1;
          end else begin
            state_d    = S_HOLD;
            if_valid_d = 1'b1;
            if_adel_d  = 1'b1;
            if_inst_d  = '0;
            if_pc_d    = pc_q;
          end
        end else begin
          // The request already on the bus must not change, so a redirect
          // only retargets pc and marks the in-flight fetch for discard.
          if (redirect) begin
            pc_d     = redir_tgt;
            cancel_d = 1'b1;
          end
          if (bus.inst_addr_ok) begin
            state_d    = S_WAIT;
            inst_req_d = 1'b0;
          end
        end
      end

      S_WAIT: begin
        if (redirect) pc_d = redir_tgt;
        if (bus.inst_data_ok) begin
          cancel_d = 1'b0;
          if (redirect || cancel_q) begin
            enter_req = 1'b1;
          end else begin
            state_d    = S_HOLD;
            if_valid_d = 1'b1;
            if_adel_d  = 1'b0;
            if_inst_d  = bus.inst_rdata;
            if_pc_d    = pc_q;
          end
        end else if (redirect) begin
          cancel_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d       = redir_tgt;
          if_valid_d = 1'b0;
          if_adel_d  = 1'b0;
          enter_req  = 1'b1;
        end else if (!stall) begin
          pc_d       = pc_q + 32'd4;
          if_valid_d = 1'b0;
          if_adel_d  = 1'b0;
          enter_req  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Launch the request for the new pc as REQ is (re)entered, so the bus
    // sees a registered, stable address for the whole REQ phase.
    if (enter_req) begin
      state_d     = S_REQ;
      inst_addr_d = pc_d;
`ifdef FETCH_ADEL_EN
      inst_req_d  = (pc_d[1:0] == 2'b00);
`else
      inst_req_d  = 1'b1;
`endif
    end
  end

  assign bus.inst_req  = inst_req_q;
  assign bus.inst_addr = inst_addr_q;
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;
  assign if_valid      = if_valid_q;
  assign if_adel       = if_adel_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  1  downstream not accepting; held instruction is consumed in a cycle with if_valid=1 and stall=0.
REQ-005 flush  input  1  exception redirect to flush_pc; has priority over branch_flag.
REQ-006 flush_pc  input  32  exception redirect target.
REQ-007 branch_flag  input  1  branch redirect request.
REQ-008 branch_target  input  32  branch redirect target.
REQ-009 inst_req  output  1  instruction bus request.
REQ-010 inst_addr  output  32  request address.
REQ-011 inst_addr_ok  input  1  address accepted this cycle.
REQ-012 inst_data_ok  input  1  read data returned this cycle.
REQ-013 inst_rdata  input  32  returned instruction word.
REQ-014 if_pc  output  32  PC of the presented instruction.
REQ-015 if_inst  output  32  presented instruction.
REQ-016 if_valid  output  1  if_pc/if_inst are valid.
REQ-017 if_adel  output  1  presented PC is misaligned (see Configuration).

Function
REQ-020 States: IDLE, REQ, WAIT, HOLD.
REQ-021 IDLE -> REQ unconditionally; inst_req=0 in IDLE.
REQ-022 REQ: inst_req=1, inst_addr=pc; inst_addr_ok -> WAIT.
REQ-023 Once raised, inst_req and inst_addr stay stable until inst_addr_ok; requests are never withdrawn.
REQ-024 At most one outstanding request; inst_data_ok is ignored outside WAIT.
REQ-025 WAIT with inst_data_ok and no cancel: next cycle HOLD, with if_inst=inst_rdata, if_pc=pc and if_valid=1 (registered; one cycle data_ok->valid).
REQ-026 HOLD with stall=1: outputs held unchanged.
REQ-027 HOLD with stall=0: instruction consumed; pc<=pc+4 (mod 2^32 wrap); next cycle REQ with if_valid=0.
REQ-028 Redirect (flush, or else branch_flag) in REQ with inst_addr_ok=1, or in WAIT: pc<=target; cancel<=1; outstanding data discarded.
REQ-029 Redirect in REQ with inst_addr_ok=0: pc_next<=target and cancel<=1; bus address is unchanged per REQ-023.
REQ-030 WAIT with inst_data_ok and cancel=1: drop the data, clear cancel, next cycle REQ at the redirected pc; if_valid stays 0.
REQ-031 Redirect in HOLD: held instruction dropped, if_valid=0 next cycle, REQ at target.
REQ-032 Redirect and inst_data_ok in the same WAIT cycle: data discarded, REQ at target next cycle.
REQ-033 A later redirect overwrites an earlier pending target; the last one wins.

Reset
REQ-040 On rst: state=IDLE, pc=RESET_PC, cancel=0, inst_req=0, inst_addr=0, if_pc=0, if_inst=0, if_valid=0, if_adel=0.
REQ-041 rst mid-transaction abandons the request; any data_ok for it after reset is ignored (state not WAIT).

Configuration
REQ-050 Macro FETCH_ADEL_EN, when defined: a pc with pc[1:0]!=0 in REQ issues no bus request. Next cycle HOLD with if_adel=1, if_inst=0, if_valid=1 and if_pc=pc; consumption and redirect behave as in REQ-027 and REQ-031.
REQ-051 Macro FETCH_ADEL_EN, when undefined: if_adel is constant 0 and pc[1:0] is passed to inst_addr unchanged.

Structure
REQ-060 The shared package holds the 32-bit address and instruction word typedefs, the fetch state enum and the default RESET_PC constant.
REQ-061 Single module, no sub-modules; the PC next-value mux stays inline.

Verification
REQ-070 Reset release with addr_ok=1 immediately and data_ok one cycle later with 32'h2408_0001 -> if_valid=1, if_pc=BFC0_0000, if_inst=2408_0001, then a request at BFC0_0004.
REQ-071 stall=1 for 5 cycles during HOLD -> outputs stable and no inst_req; on stall=0, the next request is at pc+4.
REQ-072 branch_flag with target 8000_0100 in WAIT, then data_ok 2 cycles later -> no if_valid, and the next request is at 8000_0100.
REQ-073 flush (flush_pc=BFC0_0380) and branch in the same cycle while in HOLD -> held instruction dropped, next request at BFC0_0380.
REQ-074 addr_ok held low for 4 cycles -> inst_req=1 and inst_addr constant throughout; a redirect during this window is honoured after data_ok.
REQ-075 With FETCH_ADEL_EN, branch target 8000_0102 -> no bus request, if_adel=1, if_pc=8000_0102; without the macro, inst_addr=8000_0102.
